dma_burst_sequencer: RTL and testbench

- Splits one DMA copy job (src, dst, byte length) into AXI4-legal INCR burst requests for the DMA engine's master-port back-end.
- Bursts never cross a 4 KiB boundary on either side and never exceed MaxBeats beats.
- Tracks outstanding bursts and signals job completion.
- Sits between the DMA configuration register file (slave-port side) and the AXI read/write back-end (master-port side).

---
 rtl/dma_burst_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_dma_burst_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer
//   Splits one DMA copy job (source, destination, byte length) into AXI4 INCR
//   burst requests. A burst never crosses a 4 KiB page on either side and never
//   exceeds MaxBeats beats. Issued bursts are tracked until completed, and job
//   completion is signalled once the last one finishes.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cmd_valid_i/ready_o   job request handshake (accepted only while idle)
//   cmd_src_i/dst_i/len_i job source/destination byte address and byte length
//   burst_valid_o/ready_i burst request handshake towards the back-end
//   burst_src_o/dst_o     burst start addresses
//   burst_len_o           AXI len encoding (beats-1)
//   burst_done_i          one pulse per completed burst
//   busy_o                job in progress
//   done_o, error_o       one-cycle pulses: job complete / job rejected
module dma_burst_sequencer #(
  parameter int AddrWidth      = 64,
  parameter int LenWidth       = 32,
  parameter int BeatBytes      = 8,
  parameter int MaxBeats       = 256,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_src_i,
  input  logic [AddrWidth-1:0] cmd_dst_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  output logic                 burst_valid_o,
  input  logic                 burst_ready_i,
  output logic [AddrWidth-1:0] burst_src_o,
  output logic [AddrWidth-1:0] burst_dst_o,
  output logic [7:0]           burst_len_o,
  input  logic                 burst_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int BShift = $clog2(BeatBytes);
  localparam int OutW   = $clog2(MaxOutstanding + 1);
  localparam logic [12:0]          MaxBeatsW = 13'(MaxBeats);
  localparam logic [OutW-1:0]      MaxOutW   = OutW'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] AMask     = AddrWidth'(BeatBytes - 1);
  localparam logic [LenWidth-1:0]  LMask     = LenWidth'(BeatBytes - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [AddrWidth-1:0] src_r, dst_r, src_s, dst_s;
  logic [LenWidth-1:0]  rem_r, rem_s;
  logic [OutW-1:0]      outst_r, outst_s;
  logic                 cmd_ready_r, busy_r, burst_valid_r, done_r, error_r;
  logic [AddrWidth-1:0] burst_src_r, burst_dst_r;
  logic [7:0]           burst_len_r;
  logic                 done_s, error_s, accept_s, hs_s, misaligned_s;
  logic [8:0]           hs_beats_s;
  logic [AddrWidth-1:0] hs_bytes_s;
  logic [12:0]          beats_s;

  // Beats allowed from the given pointers: 13-bit page room on both sides,
  // capped by MaxBeats and by the beats still to move.
  function automatic logic [12:0] calc_beats(input logic [AddrWidth-1:0] s,
                                             input logic [AddrWidth-1:0] d,
                                             input logic [LenWidth-1:0]  r);
    logic [12:0] room_s, room_d, lim;
    room_s = (13'd4096 - {1'b0, s[11:0]}) >> BShift;
    room_d = (13'd4096 - {1'b0, d[11:0]}) >> BShift;
    lim    = (room_s < room_d) ? room_s : room_d;
    lim    = (lim > MaxBeatsW) ? MaxBeatsW : lim;
    lim    = (r < LenWidth'(lim)) ? r[12:0] : lim;
    return lim;
  endfunction

  // Next-state computation for the FSM, pointers and outstanding counter.
  always_comb begin
    state_s      = state_r;
    src_s        = src_r;
    dst_s        = dst_r;
    rem_s        = rem_r;
    done_s       = 1'b0;
    error_s      = 1'b0;
    accept_s     = cmd_valid_i & cmd_ready_r;
    misaligned_s = (|(cmd_src_i & AMask)) | (|(cmd_dst_i & AMask)) | (|(cmd_len_i & LMask));
    hs_s         = burst_valid_r & burst_ready_i;
    // The burst being handed over is exactly what the outputs present.
    hs_beats_s   = {1'b0, burst_len_r} + 9'd1;
    hs_bytes_s   = AddrWidth'(hs_beats_s) << BShift;

    // A completion in the same cycle as an issue cancels out; a completion
    // with nothing outstanding is ignored.
    if (hs_s && !burst_done_i) begin
      outst_s = outst_r + OutW'(1);
    end else if (!hs_s && burst_done_i && (outst_r != {OutW{1'b0}})) begin
      outst_s = outst_r - OutW'(1);
    end else begin
      outst_s = outst_r;
    end

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (cmd_len_i == {LenWidth{1'b0}}) begin
            done_s = 1'b1;
          end else if (misaligned_s) begin
            error_s = 1'b1;
          end else begin
            src_s   = cmd_src_i;
            dst_s   = cmd_dst_i;
            rem_s   = cmd_len_i >> BShift;
            state_s = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (hs_s) begin
          src_s   = src_r + hs_bytes_s;
          dst_s   = dst_r + hs_bytes_s;
          rem_s   = rem_r - LenWidth'(hs_beats_s);
          state_s = (rem_s == {LenWidth{1'b0}}) ? DRAIN : ISSUE;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (outst_s == {OutW{1'b0}}) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    beats_s = calc_beats(src_s, dst_s, rem_s);
  end

  // State, pointers and registered outputs derived from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      src_r         <= {AddrWidth{1'b0}};
      dst_r         <= {AddrWidth{1'b0}};
      rem_r         <= {LenWidth{1'b0}};
      outst_r       <= {OutW{1'b0}};
      cmd_ready_r   <= 1'b0;
      busy_r        <= 1'b0;
      burst_valid_r <= 1'b0;
      burst_src_r   <= {AddrWidth{1'b0}};
      burst_dst_r   <= {AddrWidth{1'b0}};
      burst_len_r   <= 8'd0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      src_r         <= src_s;
      dst_r         <= dst_s;
      rem_r         <= rem_s;
      outst_r       <= outst_s;
      cmd_ready_r   <= (state_s == IDLE);
      busy_r        <= (state_s != IDLE);
      burst_valid_r <= (state_s == ISSUE) && (outst_s < MaxOutW);
      done_r        <= done_s;
      error_r       <= error_s;
      if (state_s == ISSUE) begin
        burst_src_r <= src_s;
        burst_dst_r <= dst_s;
        burst_len_r <= 8'(beats_s - 13'd1);
      end else begin
        burst_src_r <= {AddrWidth{1'b0}};
        burst_dst_r <= {AddrWidth{1'b0}};
        burst_len_r <= 8'd0;
      end
    end
  end

  assign cmd_ready_o   = cmd_ready_r;
  assign busy_o        = busy_r;
  assign burst_valid_o = burst_valid_r;
  assign burst_src_o   = burst_src_r;
  assign burst_dst_o   = burst_dst_r;
  assign burst_len_o   = burst_len_r;
  assign done_o        = done_r;
  assign error_o       = error_r;

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Self-checking bench for dma_burst_sequencer: a queue-based job model predicts
// every cycle's outputs; directed scenarios pin the model with literal values,
// then randomized jobs with random back-end behaviour run against the model.
module tb_dma_burst_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [63:0] cmd_src_i = 64'd0;
  logic [63:0] cmd_dst_i = 64'd0;
  logic [31:0] cmd_len_i = 32'd0;
  logic        burst_valid_o;
  logic        burst_ready_i = 1'b0;
  logic [63:0] burst_src_o;
  logic [63:0] burst_dst_o;
  logic [7:0]  burst_len_o;
  logic        burst_done_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  dma_burst_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i), .cmd_len_i(cmd_len_i),
    .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
    .burst_src_o(burst_src_o), .burst_dst_o(burst_dst_o), .burst_len_o(burst_len_o),
    .burst_done_i(burst_done_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] s;
    logic [63:0] d;
    logic [7:0]  l;
  } burst_t;

  int tests = 0;
  int fails = 0;

  // Model: bursts still to issue, outstanding count, pending pulses.
  burst_t mq[$];
  burst_t obs[$];
  int     m_out = 0;
  bit     m_active = 1'b0, m_rdy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int     done_seen = 0, err_seen = 0;
  int     rmode = 1;   // ready: 0 random, 1 always, 2 never
  int     dmode = 2;   // done: 0 random, 1 one cycle after handshake, 2 never, 3 manual
  bit     garbage = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Split a job into bursts straight from the page/size rules.
  task automatic build(logic [63:0] s, logic [63:0] d, logic [31:0] len);
    longint unsigned rem, b, rs, rd;
    rem = len / 8;
    mq.delete();
    while (rem > 0) begin
      rs = (4096 - (s % 4096)) / 8;
      rd = (4096 - (d % 4096)) / 8;
      b  = rem;
      if (rs < b) b = rs;
      if (rd < b) b = rd;
      if (256 < b) b = 256;
      mq.push_back('{s, d, 8'(b - 1)});
      s   = s + 64'(b * 8);
      d   = d + 64'(b * 8);
      rem = rem - b;
    end
  endtask

  task automatic model_edge();
    bit ev, hs, drain;
    ev     = m_active && (mq.size() > 0) && (m_out < 4);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst_i) begin
      m_active = 1'b0; m_rdy = 1'b0; m_out = 0; mq.delete();
    end else if (!m_active) begin
      if (cmd_valid_i && m_rdy) begin
        if (cmd_len_i == 32'd0) m_done = 1'b1;
        else if ((cmd_src_i % 8 != 0) || (cmd_dst_i % 8 != 0) || (cmd_len_i % 8 != 0)) m_err = 1'b1;
        else begin
          build(cmd_src_i, cmd_dst_i, cmd_len_i);
          m_active = 1'b1;
        end
      end
      m_rdy = 1'b1;
    end else begin
      drain = (mq.size() == 0);
      hs    = ev && burst_ready_i;
      if (hs) void'(mq.pop_front());
      if (hs && !burst_done_i) m_out++;
      else if (!hs && burst_done_i && m_out > 0) m_out--;
      if (drain && m_out == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  task automatic compare();
    bit ev;
    ev = m_active && (mq.size() > 0) && (m_out < 4);
    chk("cmd_ready", cmd_ready_o, !m_active && m_rdy);
    chk("busy", busy_o, m_active);
    chk("burst_valid", burst_valid_o, ev);
    chk("done", done_o, m_done);
    chk("error", error_o, m_err);
    if (ev) begin
      chk("burst_src", burst_src_o, mq[0].s);
      chk("burst_dst", burst_dst_o, mq[0].d);
      chk("burst_len", burst_len_o, mq[0].l);
    end
  endtask

  task automatic cycle();
    bit hs;
    hs = burst_valid_o && burst_ready_i;
    if (hs) obs.push_back('{burst_src_o, burst_dst_o, burst_len_o});
    @(posedge clk_i);
    model_edge();
    #1;
    compare();
    if (done_o) done_seen++;
    if (error_o) err_seen++;
    case (rmode)
      0: burst_ready_i = ($urandom_range(0, 2) != 0);
      1: burst_ready_i = 1'b1;
      2: burst_ready_i = 1'b0;
      default: ;
    endcase
    case (dmode)
      0: burst_done_i = ((m_out > 0) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 15) == 0);
      1: burst_done_i = hs;
      2: burst_done_i = 1'b0;
      default: ;
    endcase
    if (garbage) begin
      cmd_valid_i = m_active && ($urandom_range(0, 1) == 1);
      cmd_src_i   = {$urandom, $urandom};
      cmd_dst_i   = {$urandom, $urandom};
      cmd_len_i   = $urandom;
    end
  endtask

  task automatic send_cmd(logic [63:0] s, logic [63:0] d, logic [31:0] len);
    cmd_src_i = s; cmd_dst_i = d; cmd_len_i = len; cmd_valid_i = 1'b1;
    cycle();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    for (int k = 0; k < budget && m_active; k++) cycle();
    chk("job_timeout", m_active, 1'b0);
    if (m_active) begin
      rst_i = 1'b1; cycle(); rst_i = 1'b0; cycle();
    end
  endtask

  task automatic run_job(logic [63:0] s, logic [63:0] d, logic [31:0] len, int budget);
    send_cmd(s, d, len);
    wait_idle(budget);
  endtask

  task automatic chk_burst(string name, int idx, logic [63:0] s, logic [63:0] d, logic [7:0] l);
    if (idx < obs.size()) begin
      chk({name, "_src"}, obs[idx].s, s);
      chk({name, "_dst"}, obs[idx].d, d);
      chk({name, "_len"}, obs[idx].l, l);
    end else begin
      chk({name, "_missing"}, obs.size(), idx + 1);
    end
  endtask

  initial begin
    int sent;
    bit got;
    logic [63:0] s, d;
    logic [31:0] len;

    repeat (3) cycle();
    rst_i = 1'b0;
    repeat (2) cycle();

    // Two full 2 KiB bursts, back-end always ready, done right after each.
    rmode = 1; dmode = 1; obs.delete(); done_seen = 0;
    run_job(64'h8000_0000, 64'h8010_0000, 32'h1000, 200);
    chk("t1_nbursts", obs.size(), 64'd2);
    chk_burst("t1_b0", 0, 64'h8000_0000, 64'h8010_0000, 8'd255);
    chk_burst("t1_b1", 1, 64'h8000_0800, 64'h8010_0800, 8'd255);
    chk("t1_done_cnt", done_seen, 64'd1);

    // Source page crossing.
    obs.delete();
    run_job(64'h8000_0FF0, 64'h8000_2000, 32'h40, 200);
    chk("t2_nbursts", obs.size(), 64'd2);
    chk_burst("t2_b0", 0, 64'h8000_0FF0, 64'h8000_2000, 8'd1);
    chk_burst("t2_b1", 1, 64'h8000_1000, 64'h8000_2010, 8'd5);

    // Misaligned length rejected, then zero-length job completes at once.
    obs.delete(); done_seen = 0; err_seen = 0;
    send_cmd(64'h100, 64'h200, 32'h44);
    send_cmd(64'h100, 64'h200, 32'h0);
    cycle();
    chk("t3_err_cnt", err_seen, 64'd1);
    chk("t3_done_cnt", done_seen, 64'd1);
    chk("t3_no_burst", obs.size(), 64'd0);
    chk("t3_cmd_ready", cmd_ready_o, 1'b1);

    // Outstanding limit, then completions including one with a handshake.
    rmode = 1; dmode = 2; obs.delete();
    send_cmd(64'h1_0000, 64'h2_0000, 32'h4000);
    repeat (10) cycle();
    chk("t4_hs_at_limit", obs.size(), 64'd4);
    chk("t4_valid_low", burst_valid_o, 1'b0);
    chk("t4_busy", busy_o, 1'b1);
    dmode = 3; sent = 0; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      burst_done_i = (sent < 8);
      if (burst_done_i) sent++;
      cycle();
      if (done_o) got = 1'b1;
    end
    burst_done_i = 1'b0;
    chk("t4_done_seen", got, 1'b1);
    chk("t4_done_pulses", sent, 64'd8);
    chk("t4_total_bursts", obs.size(), 64'd8);

    // Stall: payload must hold while not accepted.
    rmode = 2; dmode = 2; obs.delete();
    send_cmd(64'h1000, 64'h2000, 32'h100);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t5_valid", burst_valid_o, 1'b1);
      chk("t5_src", burst_src_o, 64'h1000);
      chk("t5_dst", burst_dst_o, 64'h2000);
      chk("t5_len", burst_len_o, 8'd31);
    end
    rmode = 1; dmode = 1;
    wait_idle(200);
    chk("t5_nbursts", obs.size(), 64'd1);

    // Reset in the middle of issuing, then a clean new job.
    rmode = 1; dmode = 2; obs.delete(); done_seen = 0; err_seen = 0;
    send_cmd(64'h4000, 64'h9000, 32'h4000);
    cycle(); cycle();
    chk("t6_hs_before_rst", obs.size(), 64'd2);
    rst_i = 1'b1;
    cycle();
    chk("t6_rst_ready", cmd_ready_o, 1'b0);
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_valid", burst_valid_o, 1'b0);
    chk("t6_rst_src", burst_src_o, 64'h0);
    chk("t6_rst_len", burst_len_o, 8'd0);
    rst_i = 1'b0;
    cycle();
    chk("t6_no_done", done_seen, 64'd0);
    chk("t6_no_err", err_seen, 64'd0);
    dmode = 1; obs.delete();
    run_job(64'h8000_0000, 64'h8010_0000, 32'h1000, 200);
    chk_burst("t6_b0", 0, 64'h8000_0000, 64'h8010_0000, 8'd255);
    chk("t6_nbursts", obs.size(), 64'd2);

    // Address wrap.
    obs.delete();
    run_job(64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 32'h40, 200);
    chk_burst("wrap_b1", 1, 64'h0, 64'h10, 8'd5);

    // Random jobs with random back-end behaviour.
    rmode = 0; dmode = 0; garbage = 1'b1;
    for (int j = 0; j < 60; j++) begin
      repeat ($urandom_range(0, 3)) cycle();
      s   = {$urandom, $urandom} & ~64'h7;
      d   = {$urandom, $urandom} & ~64'h7;
      if ($urandom_range(0, 1) == 1) s = (s & ~64'hFFF) | 64'(4096 - 8 * $urandom_range(1, 64));
      if ($urandom_range(0, 1) == 1) d = (d & ~64'hFFF) | 64'(4096 - 8 * $urandom_range(1, 64));
      len = 32'(8 * $urandom_range(1, 1200));
      case ($urandom_range(0, 9))
        0: len = 32'd0;
        1: s = s | 64'($urandom_range(1, 7));
        2: len = len | 32'($urandom_range(1, 7));
        default: ;
      endcase
      run_job(s, d, len, 4000);
    end
    garbage = 1'b0; cmd_valid_i = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
